// File: rtl/mem_pkg.sv
// Shared types and default widths for the MEM-stage load/store requester.
package mem_pkg;

  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 16;
  localparam int TAG_W     = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    RESP     = 3'd3,
    WR_ISSUE = 3'd4
  } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request, data-memory and writeback channels of the MEM-stage requester.
// The slave modport is the unit itself; the master modport is the pipeline/memory side.
interface mem_access_unit_if
  import mem_pkg::*;
#(
  parameter int DW = mem_pkg::DATA_W,
  parameter int TW = mem_pkg::TAG_W
) ();
  logic          req_valid;
  logic          req_load;
  logic          req_store;
  logic [DW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [TW-1:0] req_rd;
  logic          req_ready;
  logic          mem_read;
  logic          mem_wrt;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic [TW-1:0] wb_rd;
  logic          wb_ready;
  logic          fault;
  logic [DW-1:0] fault_addr;
  logic [15:0]   load_cnt;
  logic [15:0]   store_cnt;

  modport slave (
    input  req_valid, req_load, req_store, req_addr, req_wdata, req_rd,
    input  mem_rdata, wb_ready,
    output req_ready, mem_read, mem_wrt, mem_addr, mem_wdata,
    output wb_valid, wb_data, wb_rd, fault, fault_addr, load_cnt, store_cnt
  );

  modport master (
    output req_valid, req_load, req_store, req_addr, req_wdata, req_rd,
    output mem_rdata, wb_ready,
    input  req_ready, mem_read, mem_wrt, mem_addr, mem_wdata,
    input  wb_valid, wb_data, wb_rd, fault, fault_addr, load_cnt, store_cnt
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store requester: one operation in flight, registered memory
// strobes, valid/ready load writeback and a fault pulse for rejected requests.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W    = mem_pkg::DATA_W,
  parameter int MEM_DEPTH = mem_pkg::MEM_DEPTH,
  parameter int TAG_W     = mem_pkg::TAG_W
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  state_t              state_r;
  logic                mem_read_r;
  logic                mem_wrt_r;
  logic [DATA_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic                wb_valid_r;
  logic [DATA_W-1:0]   wb_data_r;
  logic [TAG_W-1:0]    wb_rd_r;
  logic                fault_r;
  logic [DATA_W-1:0]   fault_addr_r;
  logic [15:0]         load_cnt_r;
  logic [15:0]         store_cnt_r;
  logic                accept_s;
  logic                illegal_s;

  assign accept_s  = bus.req_valid && (state_r == IDLE);
  assign illegal_s = (bus.req_load == bus.req_store) ||
                     (bus.req_addr >= DATA_W'(MEM_DEPTH));

  // Sequencer: strobes are asserted on the accepting edge so they are pure flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      mem_read_r   <= 1'b0;
      mem_wrt_r    <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      wb_valid_r   <= 1'b0;
      wb_data_r    <= '0;
      wb_rd_r      <= '0;
      fault_r      <= 1'b0;
      fault_addr_r <= '0;
      load_cnt_r   <= 16'd0;
      store_cnt_r  <= 16'd0;
    end else begin
      mem_read_r <= 1'b0;
      mem_wrt_r  <= 1'b0;
      fault_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (illegal_s) begin
              fault_r      <= 1'b1;
              fault_addr_r <= bus.req_addr;
            end else if (bus.req_load) begin
              mem_read_r <= 1'b1;
              mem_addr_r <= bus.req_addr;
              wb_rd_r    <= bus.req_rd;
              state_r    <= RD_ISSUE;
            end else begin
              mem_wrt_r   <= 1'b1;
              mem_addr_r  <= bus.req_addr;
              mem_wdata_r <= bus.req_wdata;
              state_r     <= WR_ISSUE;
            end
          end
        end
        RD_ISSUE: state_r <= RD_WAIT;
        // readData is the memory's registered output, valid one cycle after the strobe
        RD_WAIT: begin
          wb_data_r  <= bus.mem_rdata;
          wb_valid_r <= 1'b1;
          state_r    <= RESP;
        end
        RESP: begin
          if (bus.wb_ready) begin
            wb_valid_r <= 1'b0;
            load_cnt_r <= load_cnt_r + 16'd1;
            state_r    <= IDLE;
          end
        end
        WR_ISSUE: begin
          store_cnt_r <= store_cnt_r + 16'd1;
          state_r     <= IDLE;
        end
        default: begin
          wb_valid_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_r == IDLE);
  assign bus.mem_read   = mem_read_r;
  assign bus.mem_wrt    = mem_wrt_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.wb_valid   = wb_valid_r;
  assign bus.wb_data    = wb_data_r;
  assign bus.wb_rd      = wb_rd_r;
  assign bus.fault      = fault_r;
  assign bus.fault_addr = fault_addr_r;
  assign bus.load_cnt   = load_cnt_r;
  assign bus.store_cnt  = store_cnt_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: behavioural data memory, load
// scoreboard, directed timing/fault/reset/wrap scenarios.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rd_pulses = 0;
  int   wr_pulses = 0;

  logic [19:0] sbq [$];
  logic [15:0] mem    [16] = '{16'h2BCD, 16'h0111, 16'h0222, 16'h0333,
                               16'h1234, 16'h0555, 16'h0666, 16'h0777,
                               16'h0888, 16'h0999, 16'h0AAA, 16'h0BBB,
                               16'h0CCC, 16'h0DDD, 16'h0EEE, 16'h0FFF};
  logic [15:0] shadow [16] = '{16'h2BCD, 16'h0111, 16'h0222, 16'h0333,
                               16'h1234, 16'h0555, 16'h0666, 16'h0777,
                               16'h0888, 16'h0999, 16'h0AAA, 16'h0BBB,
                               16'h0CCC, 16'h0DDD, 16'h0EEE, 16'h0FFF};
  logic [15:0] rdata_r = 16'h0000;
  logic        hold_r  = 1'b0;
  logic [15:0] hold_data_r = 16'h0000;
  logic [3:0]  hold_rd_r   = 4'h0;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = rdata_r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [3:0] rd);
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.req_ready) check("ready_timeout", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_load  = ld;
    bus.req_store = st;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_rd    = rd;
    if (ld && !st && addr < 16'd16) sbq.push_back({rd, shadow[addr[3:0]]});
    if (st && !ld && addr < 16'd16) shadow[addr[3:0]] = wdata;
    tick();
    bus.req_valid = 1'b0;
    bus.req_load  = 1'b0;
    bus.req_store = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sbq.size() != 0 || !bus.req_ready) && n < 50) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(sbq.size()), 32'd0);
  endtask

  // Behavioural synchronous data memory (registered readData).
  always @(posedge clk) begin
    if (bus.mem_wrt) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
    if (bus.mem_read) rdata_r <= mem[bus.mem_addr[3:0]];
  end

  // Output monitor: strobe exclusivity, RESP stability and scoreboard pops.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_read) rd_pulses++;
      if (bus.mem_wrt) wr_pulses++;
      check("rd_wr_excl", 32'(bus.mem_read & bus.mem_wrt), 32'd0);
      if (hold_r) begin
        check("hold_data", 32'(bus.wb_data), 32'(hold_data_r));
        check("hold_rd", 32'(bus.wb_rd), 32'(hold_rd_r));
      end
      if (bus.wb_valid && bus.wb_ready) begin
        if (sbq.size() == 0) begin
          check("sb_size", 32'(sbq.size()), 32'd1);
        end else begin
          logic [19:0] e;
          e = sbq.pop_front();
          check("wb_data", 32'(bus.wb_data), 32'(e[15:0]));
          check("wb_rd", 32'(bus.wb_rd), 32'(e[19:16]));
        end
      end
      hold_r      <= bus.wb_valid && !bus.wb_ready;
      hold_data_r <= bus.wb_data;
      hold_rd_r   <= bus.wb_rd;
    end else begin
      hold_r <= 1'b0;
    end
  end

  initial begin
    logic [15:0] lc;
    logic [15:0] sc;
    int rp;
    int wp;
    bus.req_valid = 1'b0;
    bus.req_load  = 1'b0;
    bus.req_store = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 16'h0000;
    bus.req_rd    = 4'h0;
    bus.wb_ready  = 1'b1;

    // Reset state
    #1;
    check("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_mem_wrt", 32'(bus.mem_wrt), 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    check("rst_fault_addr", 32'(bus.fault_addr), 32'd0);
    check("rst_load_cnt", 32'(bus.load_cnt), 32'd0);
    check("rst_store_cnt", 32'(bus.store_cnt), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Load word 4, tag 3: latency 2 to wb_valid
    issue(1'b1, 1'b0, 16'd4, 16'h0000, 4'd3);
    check("ld_mem_read", 32'(bus.mem_read), 32'd1);
    check("ld_mem_addr", 32'(bus.mem_addr), 32'd4);
    check("ld_ready_busy", 32'(bus.req_ready), 32'd0);
    tick();
    check("ld_read_1cyc", 32'(bus.mem_read), 32'd0);
    check("ld_no_valid_e1", 32'(bus.wb_valid), 32'd0);
    tick();
    check("ld_valid_e2", 32'(bus.wb_valid), 32'd1);
    check("ld_data_e2", 32'(bus.wb_data), 32'h1234);
    check("ld_rd_e2", 32'(bus.wb_rd), 32'd3);
    tick();
    check("ld_valid_drop", 32'(bus.wb_valid), 32'd0);
    check("ld_cnt1", 32'(bus.load_cnt), 32'd1);
    check("ld_ready_back", 32'(bus.req_ready), 32'd1);

    // Store BEEF to 6, then read it back
    issue(1'b0, 1'b1, 16'd6, 16'hBEEF, 4'd0);
    check("st_mem_wrt", 32'(bus.mem_wrt), 32'd1);
    check("st_mem_addr", 32'(bus.mem_addr), 32'd6);
    check("st_mem_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    tick();
    check("st_wrt_1cyc", 32'(bus.mem_wrt), 32'd0);
    check("st_cnt1", 32'(bus.store_cnt), 32'd1);
    check("st_ready_e1", 32'(bus.req_ready), 32'd1);
    check("st_addr_hold", 32'(bus.mem_addr), 32'd6);
    issue(1'b1, 1'b0, 16'd6, 16'h0000, 4'd7);
    wait_done();
    check("ld_cnt2", 32'(bus.load_cnt), 32'd2);

    // Back-pressure: wb_ready low for 5 cycles
    bus.wb_ready = 1'b0;
    issue(1'b1, 1'b0, 16'd0, 16'h0000, 4'd9);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus.wb_valid), 32'd1);
      check("bp_data", 32'(bus.wb_data), 32'h2BCD);
      check("bp_ready_low", 32'(bus.req_ready), 32'd0);
      tick();
    end
    check("bp_cnt_held", 32'(bus.load_cnt), 32'd2);
    bus.wb_ready = 1'b1;
    tick();
    check("bp_done_valid", 32'(bus.wb_valid), 32'd0);
    check("bp_done_cnt", 32'(bus.load_cnt), 32'd3);
    check("bp_done_ready", 32'(bus.req_ready), 32'd1);

    // Illegal requests back-to-back
    lc = bus.load_cnt;
    sc = bus.store_cnt;
    rp = rd_pulses;
    wp = wr_pulses;
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 4'd1);
    check("flt1_pulse", 32'(bus.fault), 32'd1);
    check("flt1_addr", 32'(bus.fault_addr), 32'h0010);
    check("flt1_ready", 32'(bus.req_ready), 32'd1);
    issue(1'b1, 1'b1, 16'h0002, 16'h5555, 4'd2);
    check("flt2_pulse", 32'(bus.fault), 32'd1);
    check("flt2_addr", 32'(bus.fault_addr), 32'h0002);
    issue(1'b0, 1'b0, 16'h0005, 16'h0000, 4'd2);
    check("flt3_pulse", 32'(bus.fault), 32'd1);
    check("flt3_addr", 32'(bus.fault_addr), 32'h0005);
    tick();
    check("flt_pulse_end", 32'(bus.fault), 32'd0);
    check("flt_addr_hold", 32'(bus.fault_addr), 32'h0005);
    check("flt_no_read", 32'(rd_pulses), 32'(rp));
    check("flt_no_wrt", 32'(wr_pulses), 32'(wp));
    check("flt_lcnt", 32'(bus.load_cnt), 32'(lc));
    check("flt_scnt", 32'(bus.store_cnt), 32'(sc));

    // Reset during RD_WAIT
    issue(1'b1, 1'b0, 16'd4, 16'h0000, 4'd5);
    tick();
    rst = 1'b1;
    #1;
    check("mrst_mem_read", 32'(bus.mem_read), 32'd0);
    check("mrst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("mrst_load_cnt", 32'(bus.load_cnt), 32'd0);
    check("mrst_store_cnt", 32'(bus.store_cnt), 32'd0);
    sbq.delete();
    tick();
    rst = 1'b0;
    #1;
    check("mrst_ready", 32'(bus.req_ready), 32'd1);
    tick();
    issue(1'b1, 1'b0, 16'd4, 16'h0000, 4'd5);
    wait_done();
    check("mrst_ld_cnt", 32'(bus.load_cnt), 32'd1);

    // store_cnt wrap: preset near the top, then three stores
    force dut.store_cnt_r = 16'hFFFD;
    #1;
    release dut.store_cnt_r;
    tick();
    issue(1'b0, 1'b1, 16'd8, 16'h1111, 4'd0);
    tick();
    check("wrap_fffe", 32'(bus.store_cnt), 32'hFFFE);
    issue(1'b0, 1'b1, 16'd9, 16'h2222, 4'd0);
    tick();
    check("wrap_ffff", 32'(bus.store_cnt), 32'hFFFF);
    issue(1'b0, 1'b1, 16'd10, 16'h3333, 4'd0);
    tick();
    check("wrap_zero", 32'(bus.store_cnt), 32'h0000);
    issue(1'b1, 1'b0, 16'd9, 16'h0000, 4'd4);
    wait_done();

    tick();
    check("sb_drain", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store requester for the 16-bit MIPS pipeline. It accepts one memory operation at a time from the EX/MEM register and drives the data memory's MemRead/MemWrt/address/wrtData port. It captures the data memory's registered readData and returns load results to MEM/WB through a valid/ready handshake. It stalls the upstream pipeline while an operation is in flight and rejects out-of-range or malformed requests with a fault pulse.

## Interface
- DATA_W, 16, data and address width
- MEM_DEPTH, 16, number of addressable words; legal addresses are 0..MEM_DEPTH-1
- TAG_W, 4, destination-register tag width
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present from EX/MEM
- req_load  in  1  request is a load
- req_store  in  1  request is a store
- req_addr  in  DATA_W  word address
- req_wdata  in  DATA_W  store data
- req_rd  in  TAG_W  load destination tag
- req_ready  out  1  unit can accept; upstream stalls when low
- mem_read  out  1  to data memory MemRead
- mem_wrt  out  1  to data memory MemWrt
- mem_addr  out  DATA_W  to data memory address
- mem_wdata  out  DATA_W  to data memory wrtData
- mem_rdata  in  DATA_W  from data memory readData, valid the cycle after a MemRead edge
- wb_valid  out  1  load result available
- wb_data  out  DATA_W  load result
- wb_rd  out  TAG_W  load destination tag
- wb_ready  in  1  MEM/WB accepts result
- fault  out  1  one-cycle pulse on a rejected request
- fault_addr  out  DATA_W  address of the most recent fault; holds until the next fault
- load_cnt, store_cnt  out  16 each  completed loads and stores; wrap modulo 2^16

## Operation
- FSM states are IDLE, RD_ISSUE, RD_WAIT, RESP and WR_ISSUE.
- req_ready = (state == IDLE). A request is accepted on any edge where req_valid & req_ready.
- An accepted request is illegal if req_load == req_store (both high or both low), or if req_addr >= MEM_DEPTH.
  - Illegal request: no memory access. fault = 1 for the next cycle, fault_addr <= req_addr, state stays IDLE.
- Legal load: latch the address and tag, go to RD_ISSUE.
  - RD_ISSUE: mem_read = 1 and mem_addr = latched address, for exactly one cycle. Go to RD_WAIT.
  - RD_WAIT: capture mem_rdata into wb_data. Go to RESP.
  - RESP: wb_valid = 1, with wb_data and wb_rd stable. On wb_ready, load_cnt increments and the state returns to IDLE.
- Legal store: latch the address and data, go to WR_ISSUE.
  - WR_ISSUE: mem_wrt = 1 with mem_addr and mem_wdata, for one cycle. store_cnt increments and the state returns to IDLE.
  - Stores produce no writeback.
- mem_read and mem_wrt are never high in the same cycle. Both are registered outputs with no combinational path from req_*.
- mem_addr and mem_wdata hold their last values when idle.
- Reset values: state IDLE, and all outputs 0 (mem_read, mem_wrt, mem_addr, mem_wdata, wb_valid, wb_data, wb_rd, fault, fault_addr, load_cnt, store_cnt).
- Reset asserted mid-operation: the unit returns to IDLE immediately (asynchronously). mem_read/mem_wrt deassert, any pending result is discarded and the counters clear.

## Timing
- Load: accepted at edge E0 → mem_read high during E0–E1 → data memory samples at E1 → unit captures mem_rdata at E2 → wb_valid high from E2. Minimum latency from accept to wb_valid is 2 cycles.
- Back-to-back loads: IDLE is re-entered at the edge where wb_ready is seen. The earliest next accept is 1 cycle later, so loads complete at most one per 4 cycles.
- Store: accepted at E0 → mem_wrt high during E0–E1 → IDLE at E1 → next accept possible at E2. Stores complete at most one per 2 cycles.
- wb_ready low holds RESP indefinitely. wb_data and wb_rd must not change while wb_valid is high and wb_ready is low.
- fault is high for exactly the cycle E0–E1 after an illegal accept. Back-to-back illegal requests give one pulse per request, and fault_addr updates each time.
- Counter wrap: load_cnt moves 16'hFFFF → 16'h0000 with no flag.

## Structure
- Shared package mem_pkg holds:
  - the state enum (IDLE, RD_ISSUE, RD_WAIT, RESP, WR_ISSUE)
  - DATA_W, MEM_DEPTH and TAG_W defaults
- This is a single module. No sub-module is natural: the counters and FSM are small and share the same enables.

## Test plan
- Load from a preloaded memory where word 4 = 16'h1234, with req_rd = 3 and wb_ready held high → wb_valid at E2 with wb_data 16'h1234, wb_rd 3; load_cnt = 1.
- Store 16'hBEEF to addr 6, then load addr 6 → mem_wrt pulses one cycle with mem_addr 6; the load returns 16'hBEEF; store_cnt = 1.
- Load addr 0 (holds 16'h2BCD) with wb_ready low for 5 cycles → wb_valid held and wb_data stable at 16'h2BCD; req_ready low throughout; completes on the cycle wb_ready rises.
- Load addr 16'h0010, then a request with both req_load and req_store set at addr 2 → two fault pulses; fault_addr reads 16'h0010 then 16'h0002; no mem_read/mem_wrt activity; counters unchanged.
- Assert rst during RD_WAIT → mem_read, wb_valid and the counters are 0 immediately; req_ready is 1 after rst drops; the next load works normally.
- 65536 stores → store_cnt wraps to 0.
